// File: rtl/dma_bus_arbiter.sv
// DMA/CPU bus arbiter for the 8227 memory bus: block copy engine that stalls
// the core via ready and seizes the bus only on a CPU read cycle.
//
// Ports:
//   clk, nrst            clock, synchronous active-low reset
//   start                one-cycle copy request (ignored while busy)
//   src_addr, dst_addr   copy source / destination start addresses
//   length               byte count, 0 means 256
//   busy, done           copy in progress / one-cycle completion pulse
//   bytes_left           remaining byte count
//   dma_grant            DMA drives the memory bus
//   cpu_ready            ready input of the core
//   cpu_*                core side of the bus
//   mem_*                memory/peripheral side of the bus
module dma_bus_arbiter #(
    parameter int unsigned BURST = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [15:0] src_addr,
    input  logic [15:0] dst_addr,
    input  logic [7:0]  length,
    output logic        busy,
    output logic        done,
    output logic [8:0]  bytes_left,
    output logic        dma_grant,
    output logic        cpu_ready,
    input  logic [7:0]  cpu_addr_high,
    input  logic [7:0]  cpu_addr_low,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_read_not_write,
    output logic [7:0]  cpu_data_in,
    output logic [7:0]  mem_addr_high,
    output logic [7:0]  mem_addr_low,
    output logic [7:0]  mem_data_out,
    output logic        mem_read_not_write,
    input  logic [7:0]  mem_data_in
);

    localparam logic [7:0] BURST_W = 8'(BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT_REQ,
        S_RD,
        S_WR,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] src_ptr_q, src_ptr_d;
    logic [15:0] dst_ptr_q, dst_ptr_d;
    logic [8:0]  count_q, count_d;
    logic [7:0]  burst_cnt_q, burst_cnt_d;
    logic [7:0]  buf_q, buf_d;

    logic [8:0]  count_dec;
    logic [7:0]  burst_inc;
    logic        dma_active;

    assign count_dec = count_q - 9'd1;
    assign burst_inc = burst_cnt_q + 8'd1;

    // State register
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            count_q     <= '0;
            burst_cnt_q <= '0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            count_q     <= count_d;
            burst_cnt_q <= burst_cnt_d;
            buf_q       <= buf_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        count_d     = count_q;
        burst_cnt_d = burst_cnt_q;
        buf_d       = buf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_ptr_d   = src_addr;
                    dst_ptr_d   = dst_addr;
                    count_d     = (length == 8'd0) ? 9'd256
                                                   : {1'b0, length};
                    burst_cnt_d = '0;
                    state_d     = S_HALT_REQ;
                end
            end
            S_HALT_REQ: begin
                // The core honours ready only on reads, so wait for one.
                if (cpu_read_not_write) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                buf_d   = mem_data_in;
                state_d = S_WR;
            end
            S_WR: begin
                src_ptr_d = src_ptr_q + 16'd1;
                dst_ptr_d = dst_ptr_q + 16'd1;
                count_d   = count_dec;
                if (count_dec == 9'd0) begin
                    burst_cnt_d = burst_inc;
                    state_d     = S_DONE;
                end else if (burst_inc == BURST_W) begin
                    burst_cnt_d = '0;
                    state_d     = S_RELEASE;
                end else begin
                    burst_cnt_d = burst_inc;
                    state_d     = S_RD;
                end
            end
            S_RELEASE: state_d = S_HALT_REQ;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs and bus mux
    always_comb begin
        dma_active = (state_q == S_RD) || (state_q == S_WR);
        // Reset drops the grant in the same cycle so an in-flight
        // write never reaches the bus.
        dma_grant  = dma_active && nrst;
        cpu_ready  = !((state_q == S_HALT_REQ) || dma_active);
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        bytes_left = count_q;
        cpu_data_in = mem_data_in;
        if (dma_grant) begin
            if (state_q == S_RD) begin
                mem_addr_high      = src_ptr_q[15:8];
                mem_addr_low       = src_ptr_q[7:0];
                mem_read_not_write = 1'b1;
            end else begin
                mem_addr_high      = dst_ptr_q[15:8];
                mem_addr_low       = dst_ptr_q[7:0];
                mem_read_not_write = 1'b0;
            end
            mem_data_out = buf_q;
        end else begin
            mem_addr_high      = cpu_addr_high;
            mem_addr_low       = cpu_addr_low;
            mem_data_out       = cpu_data_out;
            mem_read_not_write = cpu_read_not_write;
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Testbench for dma_bus_arbiter: bus-plan model plus directed copies,
// write deferral, burst release, wrap, length 0 and mid-copy reset.
module tb_dma_bus_arbiter;

    localparam int BURST = 4;

    localparam int K_H = 1;
    localparam int K_R = 2;
    localparam int K_W = 3;
    localparam int K_L = 4;
    localparam int K_D = 5;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [7:0]  length;
    logic        busy;
    logic        done;
    logic [8:0]  bytes_left;
    logic        dma_grant;
    logic        cpu_ready;
    logic [7:0]  cpu_addr_high;
    logic [7:0]  cpu_addr_low;
    logic [7:0]  cpu_data_out;
    logic        cpu_read_not_write;
    logic [7:0]  cpu_data_in;
    logic [7:0]  mem_addr_high;
    logic [7:0]  mem_addr_low;
    logic [7:0]  mem_data_out;
    logic        mem_read_not_write;
    logic [7:0]  mem_data_in;

    logic [7:0]  mem [65536];

    int n_pass = 0;
    int n_total = 0;
    bit mon_on = 0;

    int          wr_left = 0;
    logic [15:0] wr_addr = 16'h01FF;
    logic [7:0]  wr_data = 8'hC0;
    logic [7:0]  pc = 8'h00;

    ev_t q[$];
    int  mcount = 0;

    dma_bus_arbiter #(.BURST(BURST)) dut (
        .clk                (clk),
        .nrst               (nrst),
        .start              (start),
        .src_addr           (src_addr),
        .dst_addr           (dst_addr),
        .length             (length),
        .busy               (busy),
        .done               (done),
        .bytes_left         (bytes_left),
        .dma_grant          (dma_grant),
        .cpu_ready          (cpu_ready),
        .cpu_addr_high      (cpu_addr_high),
        .cpu_addr_low       (cpu_addr_low),
        .cpu_data_out       (cpu_data_out),
        .cpu_read_not_write (cpu_read_not_write),
        .cpu_data_in        (cpu_data_in),
        .mem_addr_high      (mem_addr_high),
        .mem_addr_low       (mem_addr_low),
        .mem_data_out       (mem_data_out),
        .mem_read_not_write (mem_read_not_write),
        .mem_data_in        (mem_data_in)
    );

    always #5 clk = ~clk;

    // Memory behind the bus
    assign mem_data_in = mem[{mem_addr_high, mem_addr_low}];

    always @(posedge clk) begin
        if (mem_read_not_write === 1'b0) begin
            mem[{mem_addr_high, mem_addr_low}] <= mem_data_out;
        end
    end

    // Simple CPU: scripted writes, otherwise fetch loop
    always @(posedge clk) begin
        #2;
        if (wr_left > 0) begin
            cpu_read_not_write = 1'b0;
            {cpu_addr_high, cpu_addr_low} = wr_addr;
            cpu_data_out = wr_data;
            wr_addr = wr_addr - 16'd1;
            wr_data = wr_data + 8'd1;
            wr_left = wr_left - 1;
        end else begin
            cpu_read_not_write = 1'b1;
            cpu_addr_high = 8'h80;
            cpu_addr_low = pc;
            cpu_data_out = 8'h00;
            pc = pc + 8'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: a plan of bus cycles built when a copy is accepted
    task automatic build_plan(input logic [15:0] s, input logic [15:0] d,
                              input logic [7:0] len);
        int n;
        ev_t e;
        n = (len == 8'd0) ? 256 : int'(len);
        e.kind = K_H; e.addr = '0; e.data = '0;
        q.push_back(e);
        for (int i = 0; i < n; i++) begin
            e.kind = K_R; e.addr = s + 16'(i); e.data = '0;
            q.push_back(e);
            e.kind = K_W; e.data = mem[s + 16'(i)]; e.addr = d + 16'(i);
            q.push_back(e);
            if (((i + 1) % BURST == 0) && (i + 1 < n)) begin
                e.kind = K_L; e.addr = '0; e.data = '0;
                q.push_back(e);
                e.kind = K_H;
                q.push_back(e);
            end
        end
        e.kind = K_D; e.addr = '0; e.data = '0;
        q.push_back(e);
        mcount = n;
    endtask

    // Per-cycle compare, model advance on the clock edge
    always begin
        int  k;
        bit  eg;
        @(negedge clk);
        if (mon_on) begin
            k = (q.size() > 0) ? q[0].kind : 0;
            eg = ((k == K_R) || (k == K_W)) && (nrst === 1'b1);
            chk("busy", 32'(busy), 32'(k != 0));
            chk("done", 32'(done), 32'(k == K_D));
            chk("dma_grant", 32'(dma_grant), 32'(eg));
            chk("cpu_ready", 32'(cpu_ready),
                32'(!((k == K_H) || (k == K_R) || (k == K_W))));
            chk("bytes_left", 32'(bytes_left), 32'(mcount));
            chk("cpu_data_in", 32'(cpu_data_in), 32'(mem_data_in));
            if (eg) begin
                chk("dma_addr", 32'({mem_addr_high, mem_addr_low}),
                    32'(q[0].addr));
                chk("dma_rnw", 32'(mem_read_not_write), 32'(k == K_R));
                if (k == K_W) begin
                    chk("dma_wdata", 32'(mem_data_out), 32'(q[0].data));
                end
            end else begin
                chk("pass_addr", 32'({mem_addr_high, mem_addr_low}),
                    32'({cpu_addr_high, cpu_addr_low}));
                chk("pass_rnw", 32'(mem_read_not_write),
                    32'(cpu_read_not_write));
                chk("pass_data", 32'(mem_data_out), 32'(cpu_data_out));
            end
        end
        @(posedge clk);
        if (nrst !== 1'b1) begin
            q.delete();
            mcount = 0;
        end else begin
            bit was_idle;
            was_idle = (q.size() == 0);
            if (!was_idle) begin
                if (q[0].kind == K_H) begin
                    if (cpu_read_not_write) void'(q.pop_front());
                end else begin
                    if (q[0].kind == K_W) mcount--;
                    void'(q.pop_front());
                end
            end
            if (was_idle && start) begin
                build_plan(src_addr, dst_addr, length);
            end
        end
    end

    // Starts a copy at posedge+1; returns at posedge+1 after DONE.
    task automatic do_copy(input logic [15:0] s, input logic [15:0] d,
                           input int len, input int wr,
                           output int cyc, output int rel,
                           output int hw, output int bl0);
        bit ok;
        start = 1'b1;
        src_addr = s;
        dst_addr = d;
        length = 8'(len);
        wr_left = wr;
        wr_addr = 16'h01FF;
        wr_data = 8'hC0;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; rel = 0; hw = 0; bl0 = 0; ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) bl0 = int'(bytes_left);
            if (busy && cpu_ready && !done) rel++;
            if (busy && !cpu_ready && !dma_grant && !mem_read_not_write)
                hw++;
            if (done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("copy_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, rel, hw, bl0, errs;
        bit hit;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        nrst = 1'b0;
        start = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length = '0;
        cpu_read_not_write = 1'b1;
        cpu_addr_high = 8'h80;
        cpu_addr_low = 8'h00;
        cpu_data_out = 8'h00;
        @(posedge clk);
        mon_on = 1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ready", 32'(cpu_ready), 32'(1));
        chk("rst_grant", 32'(dma_grant), 32'(0));
        chk("rst_bytes_left", 32'(bytes_left), 32'(0));
        @(posedge clk);
        #1 nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic copy
        mem[16'h0200] = 8'h11;
        mem[16'h0201] = 8'h22;
        mem[16'h0202] = 8'h33;
        do_copy(16'h0200, 16'h0300, 3, 0, cyc, rel, hw, bl0);
        chk("basic_latency", 32'(cyc), 32'(8));
        chk("basic_bl0", 32'(bl0), 32'(3));
        chk("basic_m300", 32'(mem[16'h0300]), 32'(8'h11));
        chk("basic_m301", 32'(mem[16'h0301]), 32'(8'h22));
        chk("basic_m302", 32'(mem[16'h0302]), 32'(8'h33));
        chk("basic_ready", 32'(cpu_ready), 32'(1));

        // Write deferral: CPU pushing while the copy is requested
        mem[16'h0210] = 8'h44;
        mem[16'h0211] = 8'h55;
        do_copy(16'h0210, 16'h0310, 2, 4, cyc, rel, hw, bl0);
        chk("defer_latency", 32'(cyc), 32'(9));
        chk("defer_halt_writes", 32'(hw), 32'(3));
        chk("defer_m310", 32'(mem[16'h0310]), 32'(8'h44));
        chk("defer_m311", 32'(mem[16'h0311]), 32'(8'h55));
        chk("defer_push0", 32'(mem[16'h01FF]), 32'(8'hC0));
        chk("defer_push3", 32'(mem[16'h01FC]), 32'(8'hC3));

        // Burst release
        for (int i = 0; i < 10; i++) mem[16'h0400 + 16'(i)] = 8'h30 + 8'(i);
        do_copy(16'h0400, 16'h0500, 10, 0, cyc, rel, hw, bl0);
        chk("burst_latency", 32'(cyc), 32'(26));
        chk("burst_releases", 32'(rel), 32'(2));
        chk("burst_bl0", 32'(bl0), 32'(10));
        chk("burst_m500", 32'(mem[16'h0500]), 32'(8'h30));
        chk("burst_m509", 32'(mem[16'h0509]), 32'(8'h39));
        chk("burst_bl_end", 32'(bytes_left), 32'(0));

        // Address wrap
        mem[16'hFFFF] = 8'h5A;
        do_copy(16'hFFFF, 16'h7FFF, 1, 0, cyc, rel, hw, bl0);
        chk("wrap_latency", 32'(cyc), 32'(4));
        chk("wrap_m7fff", 32'(mem[16'h7FFF]), 32'(8'h5A));

        // Length 0 means 256
        for (int i = 0; i < 256; i++)
            mem[16'h1000 + 16'(i)] = 8'(i) ^ 8'hA5;
        do_copy(16'h1000, 16'h2000, 0, 0, cyc, rel, hw, bl0);
        chk("len0_bl0", 32'(bl0), 32'(256));
        chk("len0_latency", 32'(cyc), 32'(640));
        chk("len0_releases", 32'(rel), 32'(63));
        errs = 0;
        for (int i = 0; i < 256; i++)
            if (mem[16'h2000 + 16'(i)] !== (8'(i) ^ 8'hA5)) errs++;
        chk("len0_copy_errs", 32'(errs), 32'(0));
        chk("len0_m2100", 32'(mem[16'h2100]), 32'(8'h00));

        // Start while busy, then reset during a write
        for (int i = 0; i < 5; i++) mem[16'h4000 + 16'(i)] = 8'h70 + 8'(i);
        start = 1'b1;
        src_addr = 16'h4000;
        dst_addr = 16'h4100;
        length = 8'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        src_addr = 16'h0000;
        length = 8'd9;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("ignored_start_bl", 32'(bytes_left), 32'(4));
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (dma_grant && !mem_read_not_write) begin
                hit = 1;
                break;
            end
        end
        chk("reach_wr", 32'(hit), 32'(1));
        nrst = 1'b0;
        @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_ready", 32'(cpu_ready), 32'(1));
        chk("abort_grant", 32'(dma_grant), 32'(0));
        chk("abort_addr", 32'({mem_addr_high, mem_addr_low}),
            32'({cpu_addr_high, cpu_addr_low}));
        chk("abort_m4100", 32'(mem[16'h4100]), 32'(8'h70));
        chk("abort_m4101", 32'(mem[16'h4101]), 32'(8'h71));
        chk("abort_m4102", 32'(mem[16'h4102]), 32'(8'h00));

        // CPU runs unaffected after reset
        @(posedge clk);
        #1;
        wr_addr = 16'h00F1;
        wr_data = 8'h99;
        wr_left = 2;
        repeat (12) @(posedge clk);
        #1;
        chk("cpu_w_f1", 32'(mem[16'h00F1]), 32'(8'h99));
        chk("cpu_w_f0", 32'(mem[16'h00F0]), 32'(8'h9A));
        chk("cpu_idle_busy", 32'(busy), 32'(0));

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
